// File: rtl/event_hs_pkg.sv
// Shared types and constants for the event pin req/ack sender.
package event_hs_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ_HI   = 2'd1,
        REQ_LO   = 2'd2,
        TO_DRAIN = 2'd3
    } ev_send_state_e;

    localparam logic [3:0] ERR_TYPE_EV_TIMEOUT = 4'hA;
    localparam int         TIMEOUT_UNIT_LOG2   = 12;

endpackage

// File: rtl/event_timeout_timer.sv
// Handshake timeout timer: a 4096-cycle prescaler feeding a 31-bit unit counter,
// compared live against a programmable threshold (0 disables the timeout).
module event_timeout_timer
    import event_hs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        run,
    input  logic [30:0] threshold,
    output logic        expired
);

    logic [TIMEOUT_UNIT_LOG2-1:0] presc;
    logic [30:0]                  units;
    logic                         presc_wrap;

    assign presc_wrap = run && (presc == '1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            presc <= '0;
            units <= '0;
        end else if (run) begin
            presc <= presc + 1'b1;
            if (presc_wrap && (units != '1))
                units <= units + 31'd1;
        end
    end

    // Fire on the wrapping cycle itself so the timeout lands exactly threshold*4096 cycles after start.
    assign expired = (threshold != '0) &&
                     ((units == threshold) || (presc_wrap && ((units + 31'd1) == threshold)));

endmodule

// File: rtl/event_req_sender.sv
// Event req/ack sender: queues triggers and runs a 4-phase handshake with timeout supervision.
// Define EVENT_SENDER_ACK_SYNC_EN to pass ack_in through a 2-flop synchroniser.
module event_req_sender
    import event_hs_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int PEND_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ev_trigger,
    output logic             req_out,
    input  logic             ack_in,
    input  logic             sender_en,
    input  logic [30:0]      timeout_threshold,
    input  logic             timeout_err_det_en,
    input  logic             timeout_irq_en,
    input  logic             err_clr,
    output logic             err_vld,
    output logic [3:0]       err_type,
    output logic [15:0]      err_info,
    output logic             irq_uc,
    output logic             busy,
    output logic [CNT_W-1:0] hs_count
);

    logic              ack_s;
    logic [PEND_W-1:0] pending;
    logic              dequeue;
    logic              timer_run;
    logic              expired;
    logic              timeout;
    ev_send_state_e    state;

`ifdef EVENT_SENDER_ACK_SYNC_EN
    logic [1:0] ack_sync;

    always_ff @(posedge clk) begin
        if (rst)
            ack_sync <= '0;
        else
            ack_sync <= {ack_sync[0], ack_in};
    end

    assign ack_s = ack_sync[1];
`else
    assign ack_s = ack_in;
`endif

    // A new request is never raised while the receiver still shows ack high.
    assign dequeue = (state == IDLE) && (pending != '0) && sender_en && !ack_s;

    always_ff @(posedge clk) begin
        if (rst)
            pending <= '0;
        else if (ev_trigger && !dequeue && (pending != '1))
            pending <= pending + 1'b1;
        else if (!ev_trigger && dequeue)
            pending <= pending - 1'b1;
    end

    assign timer_run = (state == REQ_HI) || (state == REQ_LO);

    event_timeout_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (dequeue),
        .run       (timer_run),
        .threshold (timeout_threshold),
        .expired   (expired)
    );

    // An ack transition seen in the same cycle as expiry completes the phase instead of timing out.
    assign timeout = expired && (((state == REQ_HI) && !ack_s) || ((state == REQ_LO) && ack_s));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req_out  <= 1'b0;
            busy     <= 1'b0;
            hs_count <= '0;
            err_vld  <= 1'b0;
            err_type <= '0;
            err_info <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dequeue) begin
                        state   <= REQ_HI;
                        req_out <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                REQ_HI: begin
                    if (ack_s) begin
                        state   <= REQ_LO;
                        req_out <= 1'b0;
                    end else if (expired) begin
                        state   <= TO_DRAIN;
                        req_out <= 1'b0;
                    end
                end
                REQ_LO: begin
                    if (!ack_s) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        hs_count <= hs_count + 1'b1;
                    end else if (expired) begin
                        state <= TO_DRAIN;
                    end
                end
                TO_DRAIN: begin
                    req_out <= 1'b0;
                    if (!ack_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    req_out <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase

            // A clear arriving with a fresh timeout lets the fresh error through.
            if (timeout && timeout_err_det_en && (!err_vld || err_clr)) begin
                err_vld  <= 1'b1;
                err_type <= ERR_TYPE_EV_TIMEOUT;
                err_info <= 16'(hs_count);
            end else if (err_clr) begin
                err_vld <= 1'b0;
            end
        end
    end

    assign irq_uc = err_vld && timeout_irq_en;

endmodule

// File: tb/tb_event_req_sender.sv
// Self-checking bench for event_req_sender (default build, ack sampled directly).
module tb_event_req_sender;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ev_trigger = 1'b0;
    logic        req_out;
    logic        ack_in;
    logic        sender_en = 1'b0;
    logic [30:0] timeout_threshold = '0;
    logic        timeout_err_det_en = 1'b0;
    logic        timeout_irq_en = 1'b0;
    logic        err_clr = 1'b0;
    logic        err_vld;
    logic [3:0]  err_type;
    logic [15:0] err_info;
    logic        irq_uc;
    logic        busy;
    logic [15:0] hs_count;

    int errors = 0;
    int checks = 0;

    // Receiver model: auto-ack with fixed delays, or manual control from the test sequences.
    logic rx_ack = 1'b0;
    logic man_mode = 1'b0;
    logic man_ack = 1'b0;
    int   rx_rise = 1;
    int   rx_fall = 1;
    int   rx_limit = -1;
    int   rx_cnt = 0;
    int   rx_acked = 0;

    assign ack_in = man_mode ? man_ack : rx_ack;

    always #5 clk = ~clk;

    event_req_sender #(.CNT_W(16), .PEND_W(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .ev_trigger         (ev_trigger),
        .req_out            (req_out),
        .ack_in             (ack_in),
        .sender_en          (sender_en),
        .timeout_threshold  (timeout_threshold),
        .timeout_err_det_en (timeout_err_det_en),
        .timeout_irq_en     (timeout_irq_en),
        .err_clr            (err_clr),
        .err_vld            (err_vld),
        .err_type           (err_type),
        .err_info           (err_info),
        .irq_uc             (irq_uc),
        .busy               (busy),
        .hs_count           (hs_count)
    );

    always @(negedge clk) begin
        if (rst) begin
            rx_ack   = 1'b0;
            rx_cnt   = 0;
            rx_acked = 0;
        end else if (!rx_ack) begin
            if (req_out && ((rx_limit < 0) || (rx_acked < rx_limit))) begin
                rx_cnt++;
                if (rx_cnt >= rx_rise) begin
                    rx_ack = 1'b1;
                    rx_cnt = 0;
                    rx_acked++;
                end
            end else begin
                rx_cnt = 0;
            end
        end else begin
            if (!req_out) begin
                rx_cnt++;
                if (rx_cnt >= rx_fall) begin
                    rx_ack = 1'b0;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt = 0;
            end
        end
    end

    typedef struct {
        string       name;
        int          n_trig;
        bit          hold_en;
        int          rise;
        int          fall;
        int          limit;
        logic [30:0] thr;
        bit          det_en;
        bit          irq_en;
        int          exp_hs;
        bit          exp_err;
        logic [3:0]  exp_type;
        logic [15:0] exp_info;
        bit          exp_irq;
    } scen_t;

    scen_t tbl[7];
    scen_t sb[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        ev_trigger = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulseTriggers(input int n);
        for (int i = 0; i < n; i++) begin
            ev_trigger = 1'b1;
            @(negedge clk);
        end
        ev_trigger = 1'b0;
    endtask

    task automatic waitReq(input logic val, input int budget, input string name);
        int n = 0;
        while ((req_out !== val) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'd0, req_out}, {31'd0, val});
    endtask

    task automatic waitQuiet(input int budget, input string name);
        int n = 0;
        int quiet = 0;
        while ((quiet < 8) && (n < budget)) begin
            @(negedge clk);
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        checkOutput(name, quiet, 8);
    endtask

    task automatic applyStimulus(input scen_t s);
        resetDut();
        man_mode = 1'b0;
        rx_rise = s.rise;
        rx_fall = s.fall;
        rx_limit = s.limit;
        timeout_threshold = s.thr;
        timeout_err_det_en = s.det_en;
        timeout_irq_en = s.irq_en;
        sender_en = !s.hold_en;
        sb.push_back(s);
        pulseTriggers(s.n_trig);
        sender_en = 1'b1;
    endtask

    task automatic checkScenario();
        scen_t e;
        waitQuiet(20000, "quiet");
        e = sb.pop_front();
        checkOutput({e.name, ".hs_count"}, {16'd0, hs_count}, e.exp_hs);
        checkOutput({e.name, ".err_vld"}, {31'd0, err_vld}, {31'd0, e.exp_err});
        checkOutput({e.name, ".err_type"}, {28'd0, err_type}, {28'd0, e.exp_type});
        checkOutput({e.name, ".err_info"}, {16'd0, err_info}, {16'd0, e.exp_info});
        checkOutput({e.name, ".irq_uc"}, {31'd0, irq_uc}, {31'd0, e.exp_irq});
    endtask

    initial begin
        int hi_cnt;

        tbl[0] = '{"single",     1, 0, 1,    1,  -1, 31'd0, 1, 0, 1,  0, 4'h0, 16'd0, 0};
        tbl[1] = '{"three",      3, 0, 2,    3,  -1, 31'd5, 1, 0, 3,  0, 4'h0, 16'd0, 0};
        tbl[2] = '{"noack",      1, 0, 1,    1,   0, 31'd1, 1, 0, 0,  1, 4'hA, 16'd0, 0};
        tbl[3] = '{"noack_irq",  1, 0, 1,    1,   0, 31'd1, 1, 1, 0,  1, 4'hA, 16'd0, 1};
        tbl[4] = '{"noack_nodet",1, 0, 1,    1,   0, 31'd1, 0, 1, 0,  0, 4'h0, 16'd0, 0};
        tbl[5] = '{"late_ack",   1, 0, 4000, 94, -1, 31'd1, 1, 0, 1,  0, 4'h0, 16'd0, 0};
        tbl[6] = '{"third_to",   3, 0, 1,    1,   2, 31'd1, 1, 0, 2,  1, 4'hA, 16'd2, 0};

        // Reset values
        resetDut();
        @(negedge clk);
        checkOutput("rst.req_out", {31'd0, req_out}, 0);
        checkOutput("rst.busy", {31'd0, busy}, 0);
        checkOutput("rst.err_vld", {31'd0, err_vld}, 0);
        checkOutput("rst.err_type", {28'd0, err_type}, 0);
        checkOutput("rst.err_info", {16'd0, err_info}, 0);
        checkOutput("rst.irq_uc", {31'd0, irq_uc}, 0);
        checkOutput("rst.hs_count", {16'd0, hs_count}, 0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(tbl[i]);
            checkScenario();
        end

        // Saturation: 20 triggers held while disabled leave 15 queued.
        applyStimulus('{"saturate", 20, 1, 1, 1, -1, 31'd0, 1, 0, 15, 0, 4'h0, 16'd0, 0});
        checkScenario();

        // Request latency: pending registers at the trigger edge, req rises at the next edge.
        resetDut();
        man_mode = 1'b0;
        rx_rise = 1; rx_fall = 1; rx_limit = -1;
        timeout_threshold = '0;
        sender_en = 1'b1;
        ev_trigger = 1'b1;
        @(negedge clk);
        ev_trigger = 1'b0;
        checkOutput("lat.req_before", {31'd0, req_out}, 0);
        @(negedge clk);
        checkOutput("lat.req_after", {31'd0, req_out}, 1);
        waitQuiet(100, "lat.quiet");
        checkOutput("lat.hs_count", {16'd0, hs_count}, 1);

        // Timeout with ack held high afterwards, then error clear and the queued event.
        resetDut();
        man_mode = 1'b1;
        man_ack = 1'b0;
        timeout_threshold = 31'd1;
        timeout_err_det_en = 1'b1;
        timeout_irq_en = 1'b1;
        sender_en = 1'b1;
        pulseTriggers(2);
        waitReq(1'b1, 10, "drain.req_rise");
        hi_cnt = 0;
        while (req_out && (hi_cnt < 5000)) begin
            @(negedge clk);
            hi_cnt++;
        end
        checkOutput("drain.req_high_cycles", hi_cnt, 4096);
        man_ack = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("drain.busy", {31'd0, busy}, 1);
        checkOutput("drain.req_out", {31'd0, req_out}, 0);
        checkOutput("drain.err_vld", {31'd0, err_vld}, 1);
        checkOutput("drain.err_type", {28'd0, err_type}, 32'hA);
        checkOutput("drain.irq_uc", {31'd0, irq_uc}, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("clr.err_vld", {31'd0, err_vld}, 0);
        checkOutput("clr.irq_uc", {31'd0, irq_uc}, 0);
        man_ack = 1'b0;
        waitReq(1'b1, 10, "drain.next_req");
        man_ack = 1'b1;
        waitReq(1'b0, 10, "drain.next_req_fall");
        man_ack = 1'b0;
        waitQuiet(100, "drain.quiet");
        checkOutput("drain.hs_count", {16'd0, hs_count}, 1);
        checkOutput("drain.err_after", {31'd0, err_vld}, 0);

        // Reset in the middle of a handshake drops req and clears everything.
        man_ack = 1'b0;
        pulseTriggers(3);
        waitReq(1'b1, 10, "mid.req_rise");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid.req_out", {31'd0, req_out}, 0);
        checkOutput("mid.busy", {31'd0, busy}, 0);
        repeat (10) @(negedge clk);
        checkOutput("mid.pending_lost", {31'd0, busy}, 0);
        checkOutput("mid.hs_count", {16'd0, hs_count}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
